zxuno_regbus_decoder: RTL and testbench

- Upstream stage of every ZX-UNO register add-on, including the scratch register at 8'hFE. Decodes CPU I/O cycles on the two ZX-UNO ports: the address port FC3B and the data port FD3B.
- Holds the 8-bit register-select latch and drives the shared zxuno_addr / zxuno_regrd / zxuno_regwr bus consumed by all add-ons.
- Serves CPU reads of the address port with its own dout/oe_n, which the top-level read mux consumes.

---
 rtl/zxuno_regbus_pkg.sv | 33 +++
 rtl/zxuno_io_cycle_qual.sv | 51 +++++
 rtl/zxuno_regbus_decoder.sv | 153 +++++++++++++++
 tb/tb_zxuno_regbus_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zxuno_regbus_pkg.sv
// Shared definitions for the ZX-UNO register bus: port addresses, decoder
// FSM states and register numbers used by the add-ons.
package zxuno_regbus_pkg;

    localparam int unsigned IO_ADDR_W = 16;
    localparam int unsigned REG_W     = 8;

    localparam logic [IO_ADDR_W-1:0] ADDR_PORT_DEFAULT = 16'hFC3B;
    localparam logic [IO_ADDR_W-1:0] DATA_PORT_DEFAULT = 16'hFD3B;

    // Register numbers decoded by the add-ons behind this bus
    localparam logic [REG_W-1:0] REG_MASTERCONF   = 8'h00;
    localparam logic [REG_W-1:0] REG_MASTERMAPPER = 8'h01;
    localparam logic [REG_W-1:0] REG_SCRATCH      = 8'hFE;
    localparam logic [REG_W-1:0] REG_COREID       = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_WR  = 3'd1,
        ST_DATA_WR  = 3'd2,
        ST_ADDR_RD  = 3'd3,
        ST_DATA_RD  = 3'd4,
        ST_WAIT_END = 3'd5
    } state_t;

    // A plain CPU I/O cycle: IORQ low, not an interrupt acknowledge,
    // exactly one of RD/WR low.
    function automatic logic is_io_cycle(input logic iorq_n, input logic m1_n,
                                         input logic rd_n, input logic wr_n);
        return !iorq_n && m1_n && (rd_n ^ wr_n);
    endfunction

endpackage

// File: rtl/zxuno_io_cycle_qual.sv
// Qualifies raw Z80 bus signals into per-port read/write requests and
// cycle-end indications for the register-bus decoder.
module zxuno_io_cycle_qual
    import zxuno_regbus_pkg::*;
#(
    parameter logic [IO_ADDR_W-1:0] ADDR_PORT = ADDR_PORT_DEFAULT,
    parameter logic [IO_ADDR_W-1:0] DATA_PORT = DATA_PORT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IO_ADDR_W-1:0] cpu_addr,
    input  logic                 iorq_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic                 m1_n,
    output logic                 valid_rd_addr,
    output logic                 valid_wr_addr,
    output logic                 valid_rd_data,
    output logic                 valid_wr_data,
    output logic                 cycle_end,
    output logic                 rd_held
);

    logic armed;
    logic io_ok;
    logic hit_addr;
    logic hit_data;

    // After reset, ignore any cycle already in flight until IORQ is seen high
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (iorq_n) begin
            armed <= 1'b1;
        end
    end

    // Port match and cycle-type qualification
    always_comb begin
        io_ok         = armed && is_io_cycle(iorq_n, m1_n, rd_n, wr_n);
        hit_addr      = (cpu_addr == ADDR_PORT);
        hit_data      = (cpu_addr == DATA_PORT);
        valid_rd_addr = io_ok && !rd_n && hit_addr;
        valid_wr_addr = io_ok && !wr_n && hit_addr;
        valid_rd_data = io_ok && !rd_n && hit_data;
        valid_wr_data = io_ok && !wr_n && hit_data;
        cycle_end     = iorq_n || wr_n;
        rd_held       = !iorq_n && !rd_n;
    end

endmodule

// File: rtl/zxuno_regbus_decoder.sv
// ZX-UNO register bus decoder: register-select latch on the address port,
// read/write strobes for the data port, and address-port readback.
// Optional ZXUNO_ADDR_AUTOINC_EN: post-increment the select after each
// data-port access.
module zxuno_regbus_decoder
    import zxuno_regbus_pkg::*;
#(
    parameter logic [IO_ADDR_W-1:0] ADDR_PORT  = ADDR_PORT_DEFAULT,
    parameter logic [IO_ADDR_W-1:0] DATA_PORT  = DATA_PORT_DEFAULT,
    parameter logic [REG_W-1:0]     RESET_ADDR = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IO_ADDR_W-1:0] cpu_addr,
    input  logic                 iorq_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic                 m1_n,
    input  logic [REG_W-1:0]     din,
    output logic [REG_W-1:0]     zxuno_addr,
    output logic                 zxuno_regrd,
    output logic                 zxuno_regwr,
    output logic [REG_W-1:0]     dout,
    output logic                 oe_n
);

    state_t           state;
    state_t           state_nx;
    logic [REG_W-1:0] addr_nx;

    logic valid_rd_addr;
    logic valid_wr_addr;
    logic valid_rd_data;
    logic valid_wr_data;
    logic cycle_end;
    logic rd_held;

`ifdef ZXUNO_ADDR_AUTOINC_EN
    logic from_data_wr;
    logic from_data_wr_nx;
`endif

    zxuno_io_cycle_qual #(
        .ADDR_PORT (ADDR_PORT),
        .DATA_PORT (DATA_PORT)
    ) u_qual (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr      (cpu_addr),
        .iorq_n        (iorq_n),
        .rd_n          (rd_n),
        .wr_n          (wr_n),
        .m1_n          (m1_n),
        .valid_rd_addr (valid_rd_addr),
        .valid_wr_addr (valid_wr_addr),
        .valid_rd_data (valid_rd_data),
        .valid_wr_data (valid_wr_data),
        .cycle_end     (cycle_end),
        .rd_held       (rd_held)
    );

    // Next-state and next register-select decode
    always_comb begin
        state_nx = state;
        addr_nx  = zxuno_addr;
`ifdef ZXUNO_ADDR_AUTOINC_EN
        from_data_wr_nx = from_data_wr;
`endif
        case (state)
            ST_IDLE: begin
                if (valid_wr_addr) begin
                    state_nx = ST_ADDR_WR;
                    addr_nx  = din;
                end else if (valid_wr_data) begin
                    state_nx = ST_DATA_WR;
                end else if (valid_rd_addr) begin
                    state_nx = ST_ADDR_RD;
                end else if (valid_rd_data) begin
                    state_nx = ST_DATA_RD;
                end
            end
            ST_ADDR_WR: begin
                state_nx = ST_WAIT_END;
`ifdef ZXUNO_ADDR_AUTOINC_EN
                from_data_wr_nx = 1'b0;
`endif
            end
            ST_DATA_WR: begin
                state_nx = ST_WAIT_END;
`ifdef ZXUNO_ADDR_AUTOINC_EN
                from_data_wr_nx = 1'b1;
`endif
            end
            ST_ADDR_RD: begin
                if (!rd_held) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DATA_RD: begin
                if (!rd_held) begin
                    state_nx = ST_IDLE;
`ifdef ZXUNO_ADDR_AUTOINC_EN
                    addr_nx  = zxuno_addr + REG_W'(1);
`endif
                end
            end
            ST_WAIT_END: begin
                if (cycle_end) begin
                    state_nx = ST_IDLE;
`ifdef ZXUNO_ADDR_AUTOINC_EN
                    if (from_data_wr) begin
                        addr_nx = zxuno_addr + REG_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, select latch and registered bus outputs derived from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            zxuno_addr  <= RESET_ADDR;
            zxuno_regwr <= 1'b0;
            zxuno_regrd <= 1'b0;
            dout        <= '0;
            oe_n        <= 1'b1;
        end else begin
            state       <= state_nx;
            zxuno_addr  <= addr_nx;
            zxuno_regwr <= (state_nx == ST_DATA_WR);
            zxuno_regrd <= (state_nx == ST_DATA_RD);
            oe_n        <= (state_nx != ST_ADDR_RD);
            dout        <= (state_nx == ST_ADDR_RD) ? zxuno_addr : '0;
        end
    end

`ifdef ZXUNO_ADDR_AUTOINC_EN
    // Remembers whether WAIT_END was entered from a data-port write
    always_ff @(posedge clk) begin
        if (rst) begin
            from_data_wr <= 1'b0;
        end else begin
            from_data_wr <= from_data_wr_nx;
        end
    end
`endif

endmodule

// File: tb/tb_zxuno_regbus_decoder.sv
// Scoreboard bench for zxuno_regbus_decoder: stimulus pushes expected bus
// pulses, a negedge monitor measures pulses and checks them in order.
module tb_zxuno_regbus_decoder;

    localparam logic [15:0] APORT = 16'hFC3B;
    localparam logic [15:0] DPORT = 16'hFD3B;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        iorq_n, rd_n, wr_n, m1_n;
    logic [7:0]  din;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd, zxuno_regwr;
    logic [7:0]  dout;
    logic        oe_n;

    zxuno_regbus_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .iorq_n      (iorq_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .m1_n        (m1_n),
        .din         (din),
        .zxuno_addr  (zxuno_addr),
        .zxuno_regrd (zxuno_regrd),
        .zxuno_regwr (zxuno_regwr),
        .dout        (dout),
        .oe_n        (oe_n)
    );

    always #5 clk = ~clk;

    // Expected pulse: channel 0 = regwr, 1 = regrd, 2 = oe_n/dout
    typedef struct {
        int         kind;
        logic [7:0] addr;
        int         start;
        int         len;
    } ev_t;

    ev_t        q[$];
    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_addr;
    logic [7:0] scratch = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: measure each active pulse and compare with the queue head when it ends
    bit         busy[3];
    int         st[3];
    int         ln[3];
    logic [7:0] sa[3];

    task automatic finalize(input int k);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_pulse: channel %0d start %0d len %0d, expected none",
                     k, st[k], ln[k]);
        end else begin
            e = q.pop_front();
            chk("pulse_kind", k, e.kind);
            chk("pulse_start", st[k], e.start);
            chk("pulse_len", ln[k], e.len);
            chk("pulse_addr", sa[k], e.addr);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] act;
        if (mon_en) begin
            act = {~oe_n, zxuno_regrd, zxuno_regwr};
            if (zxuno_regwr === 1'b1 && zxuno_addr == 8'hFE) scratch = din;
            for (int k = 0; k < 3; k++) begin
                if (act[k] === 1'b1) begin
                    if (!busy[k]) begin
                        busy[k] = 1'b1;
                        st[k]   = cyc;
                        ln[k]   = 1;
                        sa[k]   = zxuno_addr;
                    end else begin
                        ln[k]++;
                        chk("addr_stable", zxuno_addr, sa[k]);
                    end
                    if (k == 2) chk("dout", dout, sa[k]);
                end else if (busy[k]) begin
                    busy[k] = 1'b0;
                    finalize(k);
                end
            end
        end
    end

    task automatic push(input int kind, input logic [7:0] a, input int len);
        ev_t e;
        e.kind  = kind;
        e.addr  = a;
        e.start = cyc + 1;
        e.len   = len;
        q.push_back(e);
    endtask

    // Reference model: effect of one CPU I/O cycle on the bus and select register
    task automatic model(input logic [15:0] a, input bit wr, input logic [7:0] d,
                         input int len, input bit m1low, input bit both);
        if (m1low || both) return;
        if (a == APORT) begin
            if (wr) exp_addr = d;
            else    push(2, exp_addr, len);
        end else if (a == DPORT) begin
            if (wr) push(0, exp_addr, 1);
            else    push(1, exp_addr, len);
`ifdef ZXUNO_ADDR_AUTOINC_EN
            exp_addr = exp_addr + 8'd1;
`endif
        end
    endtask

    task automatic bus_idle();
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        m1_n   = 1'b1;
        din    = 8'($urandom);
    endtask

    task automatic drive(input logic [15:0] a, input bit wr, input logic [7:0] d,
                         input bit m1low, input bit both);
        cpu_addr = a;
        din      = d;
        iorq_n   = 1'b0;
        m1_n     = !m1low;
        rd_n     = !(!wr || both);
        wr_n     = !(wr || both);
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input bit wr, input logic [7:0] d,
                             input int len, input bit m1low, input bit both, input int gap);
        model(a, wr, d, len, m1low, both);
        drive(a, wr, d, m1low, both);
        repeat (len) @(negedge clk);
        bus_idle();
        repeat (gap) @(negedge clk);
        chk("select", zxuno_addr, exp_addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int          op;
        rst      = 1'b1;
        cpu_addr = 16'h0000;
        bus_idle();
        exp_addr = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_addr", zxuno_addr, 8'h00);
        chk("rst_regrd", zxuno_regrd, 1'b0);
        chk("rst_regwr", zxuno_regwr, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_oe_n", oe_n, 1'b1);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Select the scratch register; select updates one clock after first sample
        model(APORT, 1'b1, 8'hFE, 4, 1'b0, 1'b0);
        drive(APORT, 1'b1, 8'hFE, 1'b0, 1'b0);
        @(negedge clk);
        chk("select_1clk", zxuno_addr, 8'hFE);
        repeat (3) @(negedge clk);
        bus_idle();
        repeat (2) @(negedge clk);

        // Long data write: one strobe, scratch captures the data
        cpu_cycle(DPORT, 1'b1, 8'h5A, 6, 1'b0, 1'b0, 2);
        chk("scratch", scratch, 8'h5A);
        cpu_cycle(DPORT, 1'b0, 8'h00, 3, 1'b0, 1'b0, 2);
        cpu_cycle(APORT, 1'b0, 8'h00, 4, 1'b0, 1'b0, 2);

        // Ignored cycles: interrupt acknowledge, foreign address, RD+WR both low
        cpu_cycle(DPORT, 1'b1, 8'h11, 3, 1'b1, 1'b0, 2);
        cpu_cycle(16'h7D3B, 1'b1, 8'h22, 3, 1'b0, 1'b0, 2);
        cpu_cycle(DPORT, 1'b1, 8'h33, 3, 1'b0, 1'b1, 2);

        // Reset in the middle of a data read; held IORQ must not retrigger
        push(1, exp_addr, 2);
        drive(DPORT, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_addr = 8'h00;
        chk("midrst_regrd", zxuno_regrd, 1'b0);
        chk("midrst_addr", zxuno_addr, 8'h00);
        repeat (3) @(negedge clk);
        chk("midrst_hold", zxuno_regrd, 1'b0);
        bus_idle();
        repeat (2) @(negedge clk);

        // Select wrap: two data writes starting at 8'hFF
        cpu_cycle(APORT, 1'b1, 8'hFF, 3, 1'b0, 1'b0, 2);
        cpu_cycle(DPORT, 1'b1, 8'hA1, 3, 1'b0, 1'b0, 2);
        cpu_cycle(DPORT, 1'b1, 8'hA2, 2, 1'b0, 1'b0, 2);
`ifdef ZXUNO_ADDR_AUTOINC_EN
        chk("autoinc_end", zxuno_addr, 8'h01);
`else
        chk("hold_end", zxuno_addr, 8'hFF);
`endif

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 7));
            case (op)
                0:       cpu_cycle(APORT, 1'b1, 8'($urandom), int'($urandom_range(2, 5)),
                                   1'b0, 1'b0, int'($urandom_range(2, 4)));
                1, 2:    cpu_cycle(DPORT, 1'b1, 8'($urandom), int'($urandom_range(2, 6)),
                                   1'b0, 1'b0, int'($urandom_range(2, 4)));
                3, 4:    cpu_cycle(DPORT, 1'b0, 8'h00, int'($urandom_range(1, 5)),
                                   1'b0, 1'b0, int'($urandom_range(2, 4)));
                5:       cpu_cycle(APORT, 1'b0, 8'h00, int'($urandom_range(1, 5)),
                                   1'b0, 1'b0, int'($urandom_range(2, 4)));
                6:       cpu_cycle(($urandom_range(0, 1) != 0) ? APORT : DPORT,
                                   1'($urandom), 8'($urandom), int'($urandom_range(2, 4)),
                                   1'b1, 1'b0, 2);
                default: begin
                    a = 16'($urandom);
                    if (a == APORT || a == DPORT) a = 16'h7D3B;
                    cpu_cycle(a, 1'($urandom), 8'($urandom), int'($urandom_range(2, 4)),
                              1'b0, 1'b0, 2);
                end
            endcase
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("no_open_pulse", {busy[0], busy[1], busy[2]}, 3'b000);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
